mux_key: RTL and testbench

- Parameterised key-lookup multiplexer.
- Compares an input key against NR_KEY packed {key, data} pairs and drives the data of the matching pair.
- Used throughout the datapath, e.g. in the LSU for byte/half-word extraction, store data/mask formation and load-type selection.
- Main path is combinational. It adds a hit indication and a clocked sticky miss flag for debug.

---
 rtl/mux_key.sv | 93 +++++++++
 tb/tb_mux_key.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_key.sv
// mux_key -- parameterised key-lookup multiplexer.
//
// Compares `key` against NR_KEY packed {key, data} pairs held in `lut` and
// drives the data field of the matching pair on `out`. Also reports whether
// any pair matched (`hit_o`) and keeps a sticky debug flag (`miss_seen_o`)
// that records a missing lookup since the last reset.
//
// Pair i occupies lut[PAIR_LEN*(i+1)-1 : PAIR_LEN*i]. Its key is in the upper
// KEY_LEN bits and its data in the lower DATA_LEN bits. In a source
// concatenation {k_a, d_a, k_b, d_b, ...} the first-written pair therefore
// has the highest index. When several pairs share a key, the highest index
// wins. With no match, out is all zeros.
//
// Optional build macro: MUXKEY_OUT_REG_EN
//   undefined (default) : out and hit_o are combinational, zero latency.
//   defined             : out and hit_o are registered on rising clk_i and
//                         reset asynchronously to 0. miss_seen_o still
//                         samples the pre-register hit.
//
// Ports:
//   clk_i        in   1                        clock (sticky flag, optional out reg)
//   rst_i        in   1                        asynchronous active-high reset
//   key          in   KEY_LEN                  lookup key
//   lut          in   NR_KEY*(KEY_LEN+DATA_LEN) packed pair table
//   out          out  DATA_LEN                 selected data
//   hit_o        out  1                        some pair key equals key
//   miss_seen_o  out  1                        a lookup missed since reset
module mux_key #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [KEY_LEN-1:0]                    key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  output logic [DATA_LEN-1:0]                   out,
  output logic                                  hit_o,
  output logic                                  miss_seen_o
);

  localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [NR_KEY-1:0]   match;
  // data_chain[i] is the selection after considering pairs 0..i-1.
  logic [DATA_LEN-1:0] data_chain [NR_KEY+1];
  logic [DATA_LEN-1:0] sel_data;
  logic                sel_hit;

  assign data_chain[0] = '0;

  // Each stage overrides the running selection when its pair matches. The
  // last stage is the highest index, so it has the highest priority.
  for (genvar i = 0; i < NR_KEY; i++) begin : g_pair
    logic [KEY_LEN-1:0]  pair_key;
    logic [DATA_LEN-1:0] pair_data;

    assign pair_key          = lut[PAIR_LEN*i + DATA_LEN +: KEY_LEN];
    assign pair_data         = lut[PAIR_LEN*i +: DATA_LEN];
    assign match[i]          = (pair_key == key);
    assign data_chain[i + 1] = match[i] ? pair_data : data_chain[i];
  end

  assign sel_data = data_chain[NR_KEY];
  assign sel_hit  = |match;

`ifdef MUXKEY_OUT_REG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out   <= '0;
      hit_o <= 1'b0;
    end else begin
      out   <= sel_data;
      hit_o <= sel_hit;
    end
  end
`else
  always_comb begin
    out   = sel_data;
    hit_o = sel_hit;
  end
`endif

  // Samples the combinational hit so the flag timing is the same in both builds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_seen_o <= 1'b0;
    end else if (!sel_hit) begin
      miss_seen_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_key.sv
module tb_mux_key;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Byte select: NR_KEY=4, KEY_LEN=2, DATA_LEN=8
  logic [1:0]  b_key;
  logic [39:0] b_lut;
  logic [7:0]  b_out;
  logic        b_hit, b_miss;
  // Miss: NR_KEY=2, KEY_LEN=3, DATA_LEN=4
  logic [2:0]  m_key;
  logic [13:0] m_lut;
  logic [3:0]  m_out;
  logic        m_hit, m_miss;
  // Duplicates: NR_KEY=2, KEY_LEN=2, DATA_LEN=8
  logic [1:0]  d_key;
  logic [19:0] d_lut;
  logic [7:0]  d_out;
  logic        d_hit, d_miss;
  // Store mask: NR_KEY=4, KEY_LEN=3, DATA_LEN=4
  logic [2:0]  s_key;
  logic [27:0] s_lut;
  logic [3:0]  s_out;
  logic        s_hit, s_miss;
  // Single pair: NR_KEY=1, KEY_LEN=1, DATA_LEN=1
  logic        o_key;
  logic [1:0]  o_lut;
  logic        o_out;
  logic        o_hit, o_miss;

  mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u_byte (
    .clk_i(clk), .rst_i(rst), .key(b_key), .lut(b_lut),
    .out(b_out), .hit_o(b_hit), .miss_seen_o(b_miss));

  mux_key #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(4)) u_miss (
    .clk_i(clk), .rst_i(rst), .key(m_key), .lut(m_lut),
    .out(m_out), .hit_o(m_hit), .miss_seen_o(m_miss));

  mux_key #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(8)) u_dup (
    .clk_i(clk), .rst_i(rst), .key(d_key), .lut(d_lut),
    .out(d_out), .hit_o(d_hit), .miss_seen_o(d_miss));

  mux_key #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(4)) u_mask (
    .clk_i(clk), .rst_i(rst), .key(s_key), .lut(s_lut),
    .out(s_out), .hit_o(s_hit), .miss_seen_o(s_miss));

  mux_key #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) u_one (
    .clk_i(clk), .rst_i(rst), .key(o_key), .lut(o_lut),
    .out(o_out), .hit_o(o_hit), .miss_seen_o(o_miss));

  // Wait until outputs reflect inputs applied at a falling edge.
  task automatic settle();
`ifdef MUXKEY_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (b_miss !== 1'b0) begin n_err++; $display("FAIL reset_b_miss: got %b expected 0", b_miss); end
    n_vec++; if (m_miss !== 1'b0) begin n_err++; $display("FAIL reset_m_miss: got %b expected 0", m_miss); end
    n_vec++; if (o_miss !== 1'b0) begin n_err++; $display("FAIL reset_o_miss: got %b expected 0", o_miss); end
`ifdef MUXKEY_OUT_REG_EN
    n_vec++; if (b_out !== 8'h00) begin n_err++; $display("FAIL reset_b_out: got %h expected 00", b_out); end
    n_vec++; if (b_hit !== 1'b0) begin n_err++; $display("FAIL reset_b_hit: got %b expected 0", b_hit); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_byte_select();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b_key = 2'(k);
      settle();
      n_vec++; if (b_out !== exp_b[k]) begin n_err++; $display("FAIL byte_k%0d_out: got %h expected %h", k, b_out, exp_b[k]); end
      n_vec++; if (b_hit !== 1'b1) begin n_err++; $display("FAIL byte_k%0d_hit: got %b expected 1", k, b_hit); end
    end
    @(posedge clk); #1;
    n_vec++; if (b_miss !== 1'b0) begin n_err++; $display("FAIL byte_miss_flag: got %b expected 0", b_miss); end
  endtask

  task automatic test_lut_change();
    @(negedge clk);
    b_key = 2'b10;
    b_lut = {2'b00, 8'h11, 2'b01, 8'h22, 2'b10, 8'h5A, 2'b11, 8'h44};
    settle();
    n_vec++; if (b_out !== 8'h5A) begin n_err++; $display("FAIL lut_change_out: got %h expected 5a", b_out); end
    @(negedge clk);
    b_lut = {2'b00, 8'h11, 2'b01, 8'h22, 2'b10, 8'h33, 2'b11, 8'h44};
    settle();
    n_vec++; if (b_out !== 8'h33) begin n_err++; $display("FAIL lut_restore_out: got %h expected 33", b_out); end
  endtask

  task automatic test_miss();
    @(negedge clk);
    m_key = 3'd5;
    #1;
    n_vec++; if (m_miss !== 1'b0) begin n_err++; $display("FAIL miss_flag_pre_edge: got %b expected 0", m_miss); end
`ifndef MUXKEY_OUT_REG_EN
    n_vec++; if (m_out !== 4'h0) begin n_err++; $display("FAIL miss_out: got %h expected 0", m_out); end
    n_vec++; if (m_hit !== 1'b0) begin n_err++; $display("FAIL miss_hit: got %b expected 0", m_hit); end
`endif
    @(posedge clk); #1;
`ifdef MUXKEY_OUT_REG_EN
    n_vec++; if (m_out !== 4'h0) begin n_err++; $display("FAIL miss_out: got %h expected 0", m_out); end
    n_vec++; if (m_hit !== 1'b0) begin n_err++; $display("FAIL miss_hit: got %b expected 0", m_hit); end
`endif
    n_vec++; if (m_miss !== 1'b1) begin n_err++; $display("FAIL miss_flag_set: got %b expected 1", m_miss); end
    @(negedge clk);
    m_key = 3'd1;
    settle();
    n_vec++; if (m_out !== 4'hA) begin n_err++; $display("FAIL miss_recover_out: got %h expected a", m_out); end
    n_vec++; if (m_hit !== 1'b1) begin n_err++; $display("FAIL miss_recover_hit: got %b expected 1", m_hit); end
    @(posedge clk); #1;
    n_vec++; if (m_miss !== 1'b1) begin n_err++; $display("FAIL miss_flag_sticky: got %b expected 1", m_miss); end
    n_vec++; if (b_miss !== 1'b0) begin n_err++; $display("FAIL miss_flag_isolated: got %b expected 0", b_miss); end
  endtask

  task automatic test_duplicates();
    @(negedge clk);
    d_key = 2'b01;
    settle();
    n_vec++; if (d_out !== 8'hAA) begin n_err++; $display("FAIL dup_out: got %h expected aa", d_out); end
    n_vec++; if (d_hit !== 1'b1) begin n_err++; $display("FAIL dup_hit: got %b expected 1", d_hit); end
  endtask

  task automatic test_store_mask();
    logic [2:0] keys [4];
    logic [3:0] exps [4];
    logic       hits [4];
    keys = '{3'd3, 3'd2, 3'd0, 3'd7};
    exps = '{4'b1111, 4'b0011, 4'b0000, 4'b0000};
    hits = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_key = keys[i];
      settle();
      n_vec++; if (s_out !== exps[i]) begin n_err++; $display("FAIL mask_k%0d_out: got %b expected %b", keys[i], s_out, exps[i]); end
      n_vec++; if (s_hit !== hits[i]) begin n_err++; $display("FAIL mask_k%0d_hit: got %b expected %b", keys[i], s_hit, hits[i]); end
    end
    @(negedge clk);
    s_key = 3'd0;
  endtask

  task automatic test_single_pair();
    @(negedge clk);
    o_key = 1'b0;
    settle();
    n_vec++; if (o_out !== 1'b0) begin n_err++; $display("FAIL single_k0_out: got %b expected 0", o_out); end
    n_vec++; if (o_hit !== 1'b0) begin n_err++; $display("FAIL single_k0_hit: got %b expected 0", o_hit); end
    @(negedge clk);
    o_key = 1'b1;
    settle();
    n_vec++; if (o_out !== 1'b1) begin n_err++; $display("FAIL single_k1_out: got %b expected 1", o_out); end
    n_vec++; if (o_hit !== 1'b1) begin n_err++; $display("FAIL single_k1_hit: got %b expected 1", o_hit); end
    n_vec++; if (o_miss !== 1'b1) begin n_err++; $display("FAIL single_miss_flag: got %b expected 1", o_miss); end
  endtask

`ifdef MUXKEY_OUT_REG_EN
  task automatic test_out_reg_latency();
    @(negedge clk);
    b_key = 2'b00;
    settle();
    n_vec++; if (b_out !== 8'h11) begin n_err++; $display("FAIL reg_initial_out: got %h expected 11", b_out); end
    @(negedge clk);
    b_key = 2'b10;
    #1;
    n_vec++; if (b_out !== 8'h11) begin n_err++; $display("FAIL reg_hold_out: got %h expected 11", b_out); end
    @(posedge clk); #1;
    n_vec++; if (b_out !== 8'h33) begin n_err++; $display("FAIL reg_update_out: got %h expected 33", b_out); end
  endtask
`endif

  task automatic test_async_reset();
    // m_miss is set from test_miss; every key currently hits.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_vec++; if (m_miss !== 1'b0) begin n_err++; $display("FAIL areset_m_miss: got %b expected 0", m_miss); end
    n_vec++; if (s_miss !== 1'b0) begin n_err++; $display("FAIL areset_s_miss: got %b expected 0", s_miss); end
`ifdef MUXKEY_OUT_REG_EN
    n_vec++; if (b_out !== 8'h00) begin n_err++; $display("FAIL areset_b_out: got %h expected 00", b_out); end
    n_vec++; if (b_hit !== 1'b0) begin n_err++; $display("FAIL areset_b_hit: got %b expected 0", b_hit); end
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (m_miss !== 1'b0) begin n_err++; $display("FAIL areset_hold_m_miss: got %b expected 0", m_miss); end
    n_vec++; if (b_miss !== 1'b0) begin n_err++; $display("FAIL areset_hold_b_miss: got %b expected 0", b_miss); end
  endtask

  task automatic test_miss_at_release();
    @(negedge clk);
    rst   = 1'b1;
    m_key = 3'd5;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (m_miss !== 1'b0) begin n_err++; $display("FAIL release_miss_early: got %b expected 0", m_miss); end
    @(posedge clk); #1;
    n_vec++; if (m_miss !== 1'b1) begin n_err++; $display("FAIL release_miss_set: got %b expected 1", m_miss); end
  endtask

  initial begin
    b_key = 2'b00;
    b_lut = {2'b00, 8'h11, 2'b01, 8'h22, 2'b10, 8'h33, 2'b11, 8'h44};
    m_key = 3'd1;
    m_lut = {3'd1, 4'hA, 3'd2, 4'hB};
    d_key = 2'b01;
    d_lut = {2'b01, 8'hAA, 2'b01, 8'h55};
    s_key = 3'd0;
    s_lut = {3'd0, 4'b0000, 3'd1, 4'b0001, 3'd2, 4'b0011, 3'd3, 4'b1111};
    o_key = 1'b1;
    o_lut = {1'b1, 1'b1};
    repeat (2) @(posedge clk);

    test_reset();
    test_byte_select();
    test_lut_change();
    test_miss();
    test_duplicates();
    test_store_mask();
    test_single_pair();
`ifdef MUXKEY_OUT_REG_EN
    test_out_reg_latency();
`endif
    test_async_reset();
    test_miss_at_release();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
